// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback block: opcodes, sizes, FSM states
// and the opcode legality check.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } issue_state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x 64 register file: two combinational read ports, one write port and a
// registered debug read port that returns the value from before a same-edge write.
module alu_regfile #(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [63:0]   i_wdata,
  input  logic [AW-1:0] i_raddr1,
  output logic [63:0]   o_rdata1,
  input  logic [AW-1:0] i_raddr2,
  output logic [63:0]   o_rdata2,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [63:0]   o_dbg_data
);

  logic [63:0] regs_q [NREGS];
  logic [63:0] regs_d [NREGS];
  logic [63:0] dbg_q;
  logic [63:0] dbg_d;

  // r0 is never written, so it keeps its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (i_we && (i_waddr != '0)) begin
      regs_d[i_waddr] = i_wdata;
    end
    dbg_d = regs_q[i_dbg_addr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs_q <= '{default: '0};
      dbg_q  <= '0;
    end else begin
      regs_q <= regs_d;
      dbg_q  <= dbg_d;
    end
  end

  assign o_rdata1   = (i_raddr1 == '0) ? '0 : regs_q[i_raddr1];
  assign o_rdata2   = (i_raddr2 == '0) ? '0 : regs_q[i_raddr2];
  assign o_dbg_data = dbg_q;

endmodule

// File: rtl/alu_issue.sv
// Operand issue and writeback stage for an external ALU: issue FSM with illegal-op
// trap, EX operand registers with single-level bypass, and registered writeback.
module alu_issue
  import alu_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [3:0]    i_op,
  input  logic [1:0]    i_sz,
  input  logic [AW-1:0] i_rd,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  input  logic          i_imm_en,
  input  logic [63:0]   i_imm,
  output logic [3:0]    o_alu_op,
  output logic [1:0]    o_alu_sz,
  output logic [63:0]   o_alu_src1,
  output logic [63:0]   o_alu_src2,
  input  logic [63:0]   i_alu_dest,
  output logic          o_wb_valid,
  output logic [AW-1:0] o_wb_rd,
  output logic [63:0]   o_wb_data,
  output logic          o_trap,
  output logic [3:0]    o_trap_op,
  input  logic          i_trap_clr,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [63:0]   o_dbg_data
);

  issue_state_t  state_q, state_d;
  logic          ex_valid_q, ex_valid_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [1:0]    alu_sz_q, alu_sz_d;
  logic [63:0]   alu_src1_q, alu_src1_d;
  logic [63:0]   alu_src2_q, alu_src2_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_rd_q, wb_rd_d;
  logic [63:0]   wb_data_q, wb_data_d;
  logic [3:0]    trap_op_q, trap_op_d;

  logic [63:0] rf_rdata1, rf_rdata2;
  logic        byp1, byp2, accept;
  logic [63:0] src1, src2;

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (ex_valid_q),
    .i_waddr    (ex_rd_q),
    .i_wdata    (i_alu_dest),
    .i_raddr1   (i_rs1),
    .i_raddr2   (i_rs2),
    .o_rdata1   (rf_rdata1),
    .o_rdata2   (rf_rdata2),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  // The op in EX has not reached the regfile yet, so its result is forwarded.
  assign byp1   = ex_valid_q && (ex_rd_q != '0) && (i_rs1 == ex_rd_q);
  assign byp2   = ex_valid_q && (ex_rd_q != '0) && (i_rs2 == ex_rd_q);
  assign src1   = byp1 ? i_alu_dest : rf_rdata1;
  assign src2   = i_imm_en ? i_imm : (byp2 ? i_alu_dest : rf_rdata2);
  assign accept = i_valid && (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    ex_valid_d = 1'b0;
    ex_rd_d    = ex_rd_q;
    alu_op_d   = alu_op_q;
    alu_sz_d   = alu_sz_q;
    alu_src1_d = alu_src1_q;
    alu_src2_d = alu_src2_q;
    trap_op_d  = trap_op_q;
    wb_valid_d = ex_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    if (ex_valid_q) begin
      wb_rd_d   = ex_rd_q;
      wb_data_d = i_alu_dest;
    end

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (op_legal(i_op)) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = i_rd;
            alu_op_d   = i_op;
            alu_sz_d   = i_sz;
            alu_src1_d = src1;
            alu_src2_d = src2;
          end else begin
            state_d   = ST_TRAP;
            trap_op_d = i_op;
          end
        end
      end
      ST_TRAP: begin
        if (i_trap_clr) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      alu_op_q   <= '0;
      alu_sz_q   <= '0;
      alu_src1_q <= '0;
      alu_src2_q <= '0;
      trap_op_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      alu_op_q   <= alu_op_d;
      alu_sz_q   <= alu_sz_d;
      alu_src1_q <= alu_src1_d;
      alu_src2_q <= alu_src2_d;
      trap_op_q  <= trap_op_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign o_ready    = (state_q == ST_RUN);
  assign o_trap     = (state_q == ST_TRAP);
  assign o_trap_op  = trap_op_q;
  assign o_alu_op   = alu_op_q;
  assign o_alu_sz   = alu_sz_q;
  assign o_alu_src1 = alu_src1_q;
  assign o_alu_src2 = alu_src2_q;
  assign o_wb_valid = wb_valid_q;
  assign o_wb_rd    = wb_rd_q;
  assign o_wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios followed by random traffic,
// checked against an architectural register-file model with a two-edge writeback delay.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int AW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [3:0]    i_op;
  logic [1:0]    i_sz;
  logic [AW-1:0] i_rd, i_rs1, i_rs2;
  logic          i_imm_en;
  logic [63:0]   i_imm;
  logic [3:0]    o_alu_op;
  logic [1:0]    o_alu_sz;
  logic [63:0]   o_alu_src1, o_alu_src2;
  logic [63:0]   i_alu_dest;
  logic          o_wb_valid;
  logic [AW-1:0] o_wb_rd;
  logic [63:0]   o_wb_data;
  logic          o_trap;
  logic [3:0]    o_trap_op;
  logic          i_trap_clr;
  logic [AW-1:0] i_dbg_addr;
  logic [63:0]   o_dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural view (updated at accept) and committed view (updated at writeback).
  logic [63:0]   arch [32];
  logic [63:0]   comm [32];
  logic          pipe_v;
  logic [AW-1:0] pipe_rd;
  logic [63:0]   pipe_data;
  logic          trapped;
  logic [3:0]    trap_op_m;

  alu_issue dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_sz       (i_sz),
    .i_rd       (i_rd),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .i_imm_en   (i_imm_en),
    .i_imm      (i_imm),
    .o_alu_op   (o_alu_op),
    .o_alu_sz   (o_alu_sz),
    .o_alu_src1 (o_alu_src1),
    .o_alu_src2 (o_alu_src2),
    .i_alu_dest (i_alu_dest),
    .o_wb_valid (o_wb_valid),
    .o_wb_rd    (o_wb_rd),
    .o_wb_data  (o_wb_data),
    .o_trap     (o_trap),
    .o_trap_op  (o_trap_op),
    .i_trap_clr (i_trap_clr),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [1:0] sz,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = (op == OP_SUB) ? a - b : a + b;
    case (sz)
      SZ_B:    return r & 64'h0000_0000_0000_00FF;
      SZ_H:    return r & 64'h0000_0000_0000_FFFF;
      SZ_W:    return r & 64'h0000_0000_FFFF_FFFF;
      default: return r;
    endcase
  endfunction

  assign i_alu_dest = alu_fn(o_alu_op, o_alu_sz, o_alu_src1, o_alu_src2);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      arch[i] = '0;
      comm[i] = '0;
    end
    pipe_v    = 1'b0;
    pipe_rd   = '0;
    pipe_data = '0;
    trapped   = 1'b0;
    trap_op_m = '0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, check every output.
  task automatic cyc(input logic valid, input logic [3:0] op, input logic [1:0] sz,
                     input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                     input logic [AW-1:0] rs2, input logic imm_en, input logic [63:0] imm,
                     input logic clr, input logic [AW-1:0] dbg);
    logic          acc, issued, exp_wb_v;
    logic [AW-1:0] exp_wb_rd;
    logic [63:0]   exp_wb_data, exp_dbg, a, b, res;
    i_valid = valid; i_op = op; i_sz = sz; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_imm_en = imm_en; i_imm = imm; i_trap_clr = clr; i_dbg_addr = dbg;
    @(posedge i_clk);
    exp_dbg     = comm[dbg];
    exp_wb_v    = pipe_v;
    exp_wb_rd   = pipe_rd;
    exp_wb_data = pipe_data;
    if (pipe_v && pipe_rd != '0) comm[pipe_rd] = pipe_data;
    acc    = valid && !trapped;
    issued = acc && op_legal(op);
    a   = arch[rs1];
    b   = imm_en ? imm : arch[rs2];
    res = alu_fn(op, sz, a, b);
    pipe_v = issued;
    if (issued) begin
      pipe_rd   = rd;
      pipe_data = res;
      if (rd != '0) arch[rd] = res;
    end
    if (acc && !op_legal(op)) begin
      trapped   = 1'b1;
      trap_op_m = op;
    end else if (trapped && clr) begin
      trapped = 1'b0;
    end
    #1;
    if (issued) $display("[TB] issue op=%0d sz=%0d r%0d <- r%0d, %s -> %h",
                         op, sz, rd, rs1, imm_en ? "imm" : $sformatf("r%0d", rs2), res);
    check("wb_valid", 64'(o_wb_valid), 64'(exp_wb_v));
    if (exp_wb_v) begin
      check("wb_rd", 64'(o_wb_rd), 64'(exp_wb_rd));
      check("wb_data", o_wb_data, exp_wb_data);
    end
    if (issued) begin
      check("alu_op", 64'(o_alu_op), 64'(op));
      check("alu_sz", 64'(o_alu_sz), 64'(sz));
      check("alu_src1", o_alu_src1, a);
      check("alu_src2", o_alu_src2, b);
    end
    check("ready", 64'(o_ready), 64'(!trapped));
    check("trap", 64'(o_trap), 64'(trapped));
    if (trapped) check("trap_op", 64'(o_trap_op), 64'(trap_op_m));
    check("dbg_data", o_dbg_data, exp_dbg);
  endtask

  task automatic idle(input logic [AW-1:0] dbg);
    cyc(1'b0, OP_ADD, SZ_D, '0, '0, '0, 1'b0, '0, 1'b0, dbg);
  endtask

  initial begin
    logic       v, ie, clr;
    logic [3:0] op;
    logic [63:0] imm;

    i_rst = 1'b1; i_valid = 0; i_op = 0; i_sz = 0; i_rd = 0; i_rs1 = 0; i_rs2 = 0;
    i_imm_en = 0; i_imm = 0; i_trap_clr = 0; i_dbg_addr = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_wb_valid", 64'(o_wb_valid), 64'd0);
    check("rst_trap", 64'(o_trap), 64'd0);
    check("rst_alu_src1", o_alu_src1, 64'd0);
    check("rst_dbg", o_dbg_data, 64'd0);
    i_rst = 1'b0;

    // r1 = r0 + 5
    cyc(1, OP_ADD, SZ_D, 5'd1, 5'd0, 5'd0, 1, 64'd5, 0, 5'd0);
    idle(5'd0);
    check("t1_wb_valid", 64'(o_wb_valid), 64'd1);
    check("t1_wb_rd", 64'(o_wb_rd), 64'd1);
    check("t1_wb_data", o_wb_data, 64'd5);
    idle(5'd1);
    check("t1_dbg_r1", o_dbg_data, 64'd5);

    // back-to-back dependency through the bypass path
    cyc(1, OP_ADD, SZ_D, 5'd2, 5'd1, 5'd0, 1, 64'd3, 0, 5'd0);
    cyc(1, OP_ADD, SZ_D, 5'd3, 5'd2, 5'd2, 0, 64'd0, 0, 5'd0);
    check("t2_wb_8", o_wb_data, 64'd8);
    idle(5'd0);
    check("t2_wb_16", o_wb_data, 64'd16);

    // subtract with byte and word sizing
    cyc(1, OP_SUB, SZ_B, 5'd4, 5'd0, 5'd0, 1, 64'd1, 0, 5'd0);
    cyc(1, OP_SUB, SZ_W, 5'd4, 5'd0, 5'd0, 1, 64'd1, 0, 5'd0);
    check("t3_byte", o_wb_data, 64'h0000_0000_0000_00FF);
    idle(5'd0);
    check("t3_word", o_wb_data, 64'h0000_0000_FFFF_FFFF);

    // illegal opcode trap and clear
    cyc(1, 4'b0111, SZ_D, 5'd6, 5'd1, 5'd1, 0, 64'd0, 0, 5'd0);
    check("t4_trap", 64'(o_trap), 64'd1);
    check("t4_trap_op", 64'(o_trap_op), 64'd7);
    check("t4_ready", 64'(o_ready), 64'd0);
    cyc(1, OP_ADD, SZ_D, 5'd6, 5'd1, 5'd1, 0, 64'd0, 0, 5'd6);
    check("t4_no_wb", 64'(o_wb_valid), 64'd0);
    cyc(0, OP_ADD, SZ_D, 5'd0, 5'd0, 5'd0, 0, 64'd0, 1, 5'd6);
    check("t4_ready_clr", 64'(o_ready), 64'd1);

    // write to r0 is visible on the writeback bus but discarded
    cyc(1, OP_ADD, SZ_D, 5'd0, 5'd0, 5'd0, 1, 64'd9, 0, 5'd0);
    idle(5'd0);
    check("t5_wb_valid", 64'(o_wb_valid), 64'd1);
    check("t5_wb_rd", 64'(o_wb_rd), 64'd0);
    check("t5_wb_data", o_wb_data, 64'd9);
    idle(5'd0);
    check("t5_r0", o_dbg_data, 64'd0);

    // asynchronous reset with an op in EX
    cyc(1, OP_ADD, SZ_D, 5'd5, 5'd1, 5'd0, 1, 64'd77, 0, 5'd0);
    #2 i_rst = 1'b1;
    #1;
    check("t6_alu_op", 64'(o_alu_op), 64'd0);
    check("t6_alu_src1", o_alu_src1, 64'd0);
    check("t6_alu_src2", o_alu_src2, 64'd0);
    check("t6_wb_valid", 64'(o_wb_valid), 64'd0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    idle(5'd5);
    check("t6_no_wb", 64'(o_wb_valid), 64'd0);
    idle(5'd1);
    check("t6_r1_clear", o_dbg_data, 64'd0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      ie  = $urandom_range(0, 1) != 0;
      imm = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)}
                                        : 64'($urandom_range(0, 255));
      clr = ($urandom_range(0, 3) == 0);
      cyc(v, op, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)),
          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), ie, imm, clr,
          AW'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
